mem_responder: RTL and testbench

Single-port register-file responder that is the target end of the `en`/`wr`/`addr` access interface driven by the address generator. It latches one request at a time, waits a programmable number of cycles, then performs the write or read and reports completion. It sits behind the stimulus driver as the device under test for access-protocol benches and keeps saturating access statistics.

---
 rtl/mem_resp_pkg.sv | 20 ++
 rtl/mem_responder_sat_counter.sv | 40 ++++
 rtl/mem_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_responder register-file target:
//   - mem_resp_state_t : responder FSM state encoding (IDLE, WAIT, RESP)
//   - MEM_RESP_CNT_W   : width of the access statistics counters
//   - MEM_RESP_CNT_MAX : value at which the statistics counters saturate
// -----------------------------------------------------------------------------
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_t;

  localparam int MEM_RESP_CNT_W = 16;

  localparam logic [MEM_RESP_CNT_W-1:0] MEM_RESP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_responder_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at MAX instead of wrapping.
// Parameters:
//   W   : counter width
//   MAX : saturation value
// Ports:
//   i_clk   : clock, rising edge
//   i_rst   : synchronous active-high reset, clears the count
//   i_inc   : increment request for this cycle
//   o_count : registered count value
// -----------------------------------------------------------------------------
module sat_counter
  import mem_resp_pkg::*;
#(
  parameter int            W   = MEM_RESP_CNT_W,
  parameter logic [W-1:0]  MAX = {W{1'b1}}
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register: clear on reset, step on i_inc until MAX is reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-port register-file responder for the en/wr/addr access interface.
// One request is latched at a time; after WAIT_CYCLES extra cycles the write
// or read is performed and a one-cycle o_done pulse reports completion.
// Completed writes and reads are tallied in saturating counters.
//
// Optional feature macro: MEM_RESP_ERR_EN
//   defined   : an accepted address >= DEPTH completes with o_err=1
//   undefined : o_err is tied low
//   In both builds out-of-range writes are dropped, out-of-range reads
//   return zero, and the counters still increment.
//
// Parameters:
//   AW, DW       : address / data width
//   DEPTH        : implemented words (1..2**AW)
//   WAIT_CYCLES  : extra cycles between accept and completion (0..15)
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   i_en         : request valid
//   i_wr         : 1 = write, 0 = read
//   i_addr       : word address
//   i_wdata      : write data
//   o_ready      : idle and able to accept
//   o_done       : one-cycle completion pulse
//   o_rdata      : read data, valid with o_done for reads
//   o_err        : out-of-range flag, valid with o_done
//   o_wr_count   : completed writes (saturating)
//   o_rd_count   : completed reads (saturating)
// -----------------------------------------------------------------------------
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int AW          = 6,
  parameter int DW          = 8,
  parameter int DEPTH       = 48,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_wr,
  input  logic [AW-1:0]             i_addr,
  input  logic [DW-1:0]             i_wdata,
  output logic                      o_ready,
  output logic                      o_done,
  output logic [DW-1:0]             o_rdata,
  output logic                      o_err,
  output logic [MEM_RESP_CNT_W-1:0] o_wr_count,
  output logic [MEM_RESP_CNT_W-1:0] o_rd_count
);

  mem_resp_state_t r_state;
  logic [3:0]      r_wait_cnt;
  logic            r_wr;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_ready;
  logic            r_done;
  logic            r_err;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   r_mem [DEPTH];

  logic w_in_range;
  logic w_resp;
  logic w_wr_inc;
  logic w_rd_inc;

  // Extra leading zero keeps the compare valid when DEPTH == 2**AW.
  assign w_in_range = ({1'b0, r_addr} < (AW+1)'(DEPTH));
  assign w_resp     = (r_state == RESP);
  assign w_wr_inc   = w_resp & r_wr;
  assign w_rd_inc   = w_resp & ~r_wr;

  // Request FSM: accept, count down the wait, then complete with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= 4'd0;
      r_wr       <= 1'b0;
      r_addr     <= {AW{1'b0}};
      r_wdata    <= {DW{1'b0}};
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= {DW{1'b0}};
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_en) begin
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state    <= WAIT;
              r_wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        RESP: begin
          // ready returns together with done so a new request can be
          // accepted on the very next edge.
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
`ifdef MEM_RESP_ERR_EN
          r_err <= ~w_in_range;
`else
          r_err <= 1'b0;
`endif
          if (!r_wr) begin
            r_rdata <= w_in_range ? r_mem[r_addr] : {DW{1'b0}};
          end else begin
            r_rdata <= r_rdata;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr_inc && w_in_range) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  sat_counter #(
    .W   (MEM_RESP_CNT_W),
    .MAX (MEM_RESP_CNT_MAX)
  ) u_wr_count (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_wr_inc),
    .o_count (o_wr_count)
  );

  sat_counter #(
    .W   (MEM_RESP_CNT_W),
    .MAX (MEM_RESP_CNT_MAX)
  ) u_rd_count (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_rd_inc),
    .o_count (o_rd_count)
  );

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Self-checking bench for mem_responder. Instance 0 uses WAIT_CYCLES=2,
// instance 1 uses WAIT_CYCLES=0. A behavioural model (array memory plus
// saturating tallies) predicts every response.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 48;
  localparam int WAIT0 = 2;
  localparam int WAIT1 = 0;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en       [2];
  logic          wr       [2];
  logic [AW-1:0] addr     [2];
  logic [DW-1:0] wdata    [2];
  logic          ready    [2];
  logic          done     [2];
  logic [DW-1:0] rdata    [2];
  logic          err      [2];
  logic [15:0]   wr_count [2];
  logic [15:0]   rd_count [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_mem   [2][64];
  bit         m_valid [2][64];
  int         m_wc    [2];
  int         m_rc    [2];
  logic [7:0] m_rd    [2];
  logic       m_err   [2];

  always #5 clk = ~clk;

  mem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT0)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_wr(wr[0]), .i_addr(addr[0]),
    .i_wdata(wdata[0]), .o_ready(ready[0]), .o_done(done[0]), .o_rdata(rdata[0]),
    .o_err(err[0]), .o_wr_count(wr_count[0]), .o_rd_count(rd_count[0])
  );

  mem_responder #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_wr(wr[1]), .i_addr(addr[1]),
    .i_wdata(wdata[1]), .o_ready(ready[1]), .o_done(done[1]), .o_rdata(rdata[1]),
    .o_err(err[1]), .o_wr_count(wr_count[1]), .o_rd_count(rd_count[1])
  );

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_wc[s]  = 0;
      m_rc[s]  = 0;
      m_rd[s]  = 8'h00;
      m_err[s] = 1'b0;
    end
  endfunction

  function automatic void model_step(input int s, input bit w, input logic [5:0] a,
                                     input logic [7:0] d);
    bit inr;
    inr = (int'(a) < DEPTH);
    if (w) begin
      if (inr) begin
        m_mem[s][a]   = d;
        m_valid[s][a] = 1'b1;
      end
      m_wc[s] = (m_wc[s] >= 65535) ? 65535 : m_wc[s] + 1;
    end else begin
      m_rd[s] = inr ? m_mem[s][a] : 8'h00;
      m_rc[s] = (m_rc[s] >= 65535) ? 65535 : m_rc[s] + 1;
    end
    m_err[s] = ERR_EN & ~inr;
  endfunction

  // Issue one request on instance s (called and returning at a negedge).
  task automatic access(input int s, input bit w, input logic [5:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic e,
                        output logic [15:0] wc, output logic [15:0] rc);
    int guard;
    guard = 0;
    while (ready[s] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    en[s] = 1'b1; wr[s] = w; addr[s] = a; wdata[s] = d;
    @(posedge clk);
    @(negedge clk);
    en[s] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[s] === 1'b1) begin
        lat = i;
        break;
      end
    end
    rd = rdata[s]; e = err[s]; wc = wr_count[s]; rc = rd_count[s];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      en[s] = 1'b0; wr[s] = 1'b0; addr[s] = 6'h00; wdata[s] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      n_tests++; if (ready[s] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d] got %b want 1", s, ready[s]); end
      n_tests++; if (done[s] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d] got %b want 0", s, done[s]); end
      n_tests++; if (rdata[s] !== 8'h00) begin n_fail++; $display("FAIL reset_rdata[%0d] got %h want 00", s, rdata[s]); end
      n_tests++; if (err[s] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d] got %b want 0", s, err[s]); end
      n_tests++; if (wr_count[s] !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_count[%0d] got %h want 0", s, wr_count[s]); end
      n_tests++; if (rd_count[s] !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_count[%0d] got %h want 0", s, rd_count[s]); end
    end
  endtask

  task automatic test_random(input int s, input int n);
    int lat, exp_lat;
    logic [7:0] rd, d;
    logic e;
    logic [15:0] wc, rc;
    bit w;
    logic [5:0] a;
    exp_lat = (s == 0) ? WAIT0 + 1 : WAIT1 + 1;
    for (int k = 0; k < n; k++) begin
      w = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) a = 6'($urandom_range(DEPTH, 63));
      else a = 6'($urandom_range(0, DEPTH - 1));
      if (!w && int'(a) < DEPTH && !m_valid[s][a]) w = 1'b1;
      d = 8'($urandom);
      access(s, w, a, d, lat, rd, e, wc, rc);
      model_step(s, w, a, d);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d] got %0d want %0d", s, lat, exp_lat); end
      n_tests++; if (rd !== m_rd[s]) begin n_fail++; $display("FAIL rnd_rdata[%0d] wr=%b addr=%h got %h want %h", s, w, a, rd, m_rd[s]); end
      n_tests++; if (e !== m_err[s]) begin n_fail++; $display("FAIL rnd_err[%0d] addr=%h got %b want %b", s, a, e, m_err[s]); end
      n_tests++; if (wc !== 16'(m_wc[s])) begin n_fail++; $display("FAIL rnd_wr_count[%0d] got %h want %h", s, wc, 16'(m_wc[s])); end
      n_tests++; if (rc !== 16'(m_rc[s])) begin n_fail++; $display("FAIL rnd_rd_count[%0d] got %h want %h", s, rc, 16'(m_rc[s])); end
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [7:0] rd;
    logic e;
    logic [15:0] wc, rc;
    access(0, 1'b1, 6'h05, 8'hA5, lat, rd, e, wc, rc);
    model_step(0, 1'b1, 6'h05, 8'hA5);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", lat); end
    n_tests++; if (wc !== 16'd1) begin n_fail++; $display("FAIL wr_count got %h want 1", wc); end
    access(0, 1'b0, 6'h05, 8'h00, lat, rd, e, wc, rc);
    model_step(0, 1'b0, 6'h05, 8'h00);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got %0d want 3", lat); end
    n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rd_data got %h want a5", rd); end
    n_tests++; if (rc !== 16'd1) begin n_fail++; $display("FAIL rd_count got %h want 1", rc); end
    n_tests++; if (wc !== 16'd1) begin n_fail++; $display("FAIL rd_wr_count got %h want 1", wc); end
    test_random(0, 30);
  endtask

  task automatic test_busy();
    int n_done, b2b, exp_done;
    bit prev;
    n_done = 0; b2b = 0; prev = 1'b0;
    exp_done = (10 - 1) / (WAIT0 + 2) + 1;
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 6'h05; wdata[0] = 8'h00;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 9) en[0] = 1'b0;
      if (done[0] === 1'b1) begin
        n_done++;
        if (prev) b2b++;
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
    for (int i = 0; i < exp_done; i++) model_step(0, 1'b0, 6'h05, 8'h00);
    n_tests++; if (n_done !== exp_done) begin n_fail++; $display("FAIL busy_done_count got %0d want %0d", n_done, exp_done); end
    n_tests++; if (b2b !== 0) begin n_fail++; $display("FAIL busy_done_pulse_width got %0d want 0", b2b); end
    n_tests++; if (rd_count[0] !== 16'(m_rc[0])) begin n_fail++; $display("FAIL busy_rd_count got %h want %h", rd_count[0], 16'(m_rc[0])); end
    n_tests++; if (rdata[0] !== m_rd[0]) begin n_fail++; $display("FAIL busy_rdata got %h want %h", rdata[0], m_rd[0]); end
    n_tests++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL busy_ready got %b want 1", ready[0]); end
  endtask

  task automatic test_out_of_range();
    int lat;
    logic [7:0] rd;
    logic e;
    logic [15:0] wc, rc;
    access(0, 1'b1, 6'h07, 8'hC3, lat, rd, e, wc, rc);
    model_step(0, 1'b1, 6'h07, 8'hC3);
    access(0, 1'b0, 6'h07, 8'h00, lat, rd, e, wc, rc);
    model_step(0, 1'b0, 6'h07, 8'h00);
    n_tests++; if (rd !== 8'hC3) begin n_fail++; $display("FAIL oor_setup_rdata got %h want c3", rd); end
    access(0, 1'b1, 6'h30, 8'h5A, lat, rd, e, wc, rc);
    model_step(0, 1'b1, 6'h30, 8'h5A);
    n_tests++; if (e !== ERR_EN) begin n_fail++; $display("FAIL oor_wr_err got %b want %b", e, ERR_EN); end
    n_tests++; if (rd !== 8'hC3) begin n_fail++; $display("FAIL oor_wr_rdata_hold got %h want c3", rd); end
    n_tests++; if (wc !== 16'(m_wc[0])) begin n_fail++; $display("FAIL oor_wr_count got %h want %h", wc, 16'(m_wc[0])); end
    access(0, 1'b0, 6'h30, 8'h00, lat, rd, e, wc, rc);
    model_step(0, 1'b0, 6'h30, 8'h00);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_rd_rdata got %h want 00", rd); end
    n_tests++; if (e !== ERR_EN) begin n_fail++; $display("FAIL oor_rd_err got %b want %b", e, ERR_EN); end
    n_tests++; if (rc !== 16'(m_rc[0])) begin n_fail++; $display("FAIL oor_rd_count got %h want %h", rc, 16'(m_rc[0])); end
    n_tests++; if (lat !== WAIT0 + 1) begin n_fail++; $display("FAIL oor_latency got %0d want %0d", lat, WAIT0 + 1); end
  endtask

  task automatic test_zero_wait();
    test_random(1, 20);
  endtask

  task automatic test_reset_mid();
    int lat, n_done;
    logic [7:0] rd;
    logic e;
    logic [15:0] wc, rc;
    access(0, 1'b1, 6'h02, 8'h22, lat, rd, e, wc, rc);
    model_step(0, 1'b1, 6'h02, 8'h22);
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'h02; wdata[0] = 8'h11;
    @(posedge clk);
    @(negedge clk);
    en[0] = 1'b0;
    n_tests++; if (ready[0] !== 1'b0) begin n_fail++; $display("FAIL mid_busy_ready got %b want 0", ready[0]); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    // A request presented together with reset must be ignored.
    en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 6'h02; wdata[0] = 8'h33;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en[0] = 1'b0;
    n_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[0] === 1'b1) n_done++;
    end
    n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL mid_no_done got %0d want 0", n_done); end
    n_tests++; if (wr_count[0] !== 16'h0000) begin n_fail++; $display("FAIL mid_wr_count got %h want 0", wr_count[0]); end
    n_tests++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", ready[0]); end
    access(0, 1'b0, 6'h02, 8'h00, lat, rd, e, wc, rc);
    model_step(0, 1'b0, 6'h02, 8'h00);
    n_tests++; if (rd !== 8'h22) begin n_fail++; $display("FAIL mid_read_back got %h want 22", rd); end
    n_tests++; if (rc !== 16'(m_rc[0])) begin n_fail++; $display("FAIL mid_rd_count got %h want %h", rc, 16'(m_rc[0])); end
    n_tests++; if (wc !== 16'(m_wc[0])) begin n_fail++; $display("FAIL mid_wr_count_after got %h want %h", wc, 16'(m_wc[0])); end
  endtask

  task automatic test_saturation();
    int lat;
    logic [7:0] rd, d;
    logic e;
    logic [15:0] wc, rc;
    force dut.u_wr_count.r_count = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.u_wr_count.r_count;
    m_wc[0] = 65533;
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom);
      access(0, 1'b1, 6'h09, d, lat, rd, e, wc, rc);
      model_step(0, 1'b1, 6'h09, d);
      n_tests++; if (wc !== 16'(m_wc[0])) begin n_fail++; $display("FAIL sat_wr_count[%0d] got %h want %h", k, wc, 16'(m_wc[0])); end
    end
    access(0, 1'b0, 6'h09, 8'h00, lat, rd, e, wc, rc);
    model_step(0, 1'b0, 6'h09, 8'h00);
    n_tests++; if (rd !== m_rd[0]) begin n_fail++; $display("FAIL sat_read_back got %h want %h", rd, m_rd[0]); end
    n_tests++; if (wc !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got %h want ffff", wc); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_busy();
    test_out_of_range();
    test_zero_wait();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached, run did not complete");
    $fatal(1, "watchdog");
  end

endmodule
